// File: rtl/ecg_channel_center_if.sv
// rtl/ecg_channel_center_if.sv - Sample-in / centered-sample-out stream bundle for ecg_channel_center
interface ecg_channel_center_if #(
   parameter int N_CH   = 8,
   parameter int N_SAMP = 368,
   parameter int N_BITS = 22
);
   logic [N_BITS-1:0]         in_data;
   logic                      in_valid;
   logic                      in_ready;
   logic [N_BITS:0]           out_data;
   logic [$clog2(N_CH)-1:0]   out_ch;
   logic [$clog2(N_SAMP)-1:0] out_idx;
   logic                      out_last;
   logic                      out_valid;
   logic                      out_ready;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_ch, out_idx, out_last, out_valid
   );
   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_ch, out_idx, out_last, out_valid
   );
endinterface

// File: rtl/ecg_channel_center.sv
// rtl/ecg_channel_center.sv - Per-channel mean removal over one buffered multichannel ECG frame
// Buffers a frame, divides each channel sum by N_SAMP bit-serially, then replays the frame minus the mean.
module ecg_channel_center #(
   parameter int N_CH   = 8,
   parameter int N_SAMP = 368,
   parameter int N_BITS = 22
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_strt,
   output logic                o_busy,
   output logic                o_done,
   ecg_channel_center_if.slave io_bus
);
   localparam int ACC_BITS  = N_BITS + $clog2(N_SAMP);
   localparam int CH_BITS   = $clog2(N_CH);
   localparam int IDX_BITS  = $clog2(N_SAMP);
   localparam int DEPTH     = N_CH * N_SAMP;
   localparam int ADDR_BITS = $clog2(DEPTH);
   localparam int REM_BITS  = IDX_BITS + 1;
   localparam int RW        = REM_BITS - 1;
   localparam int BIT_BITS  = $clog2(ACC_BITS + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LOAD   = 2'd1;
   localparam logic [1:0] S_DIVIDE = 2'd2;
   localparam logic [1:0] S_EMIT   = 2'd3;

   localparam logic [CH_BITS-1:0]  LAST_CH  = CH_BITS'(N_CH - 1);
   localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(N_SAMP - 1);
   localparam logic [REM_BITS-1:0] DIVISOR  = REM_BITS'(N_SAMP);
   localparam logic [BIT_BITS-1:0] LAST_BIT = BIT_BITS'(ACC_BITS);

   logic [1:0]                 r_state;
   logic [CH_BITS-1:0]         r_ch;
   logic [IDX_BITS-1:0]        r_idx;
   logic [ADDR_BITS-1:0]       r_addr;
   logic signed [ACC_BITS-1:0] r_acc [N_CH];
   logic signed [N_BITS-1:0]   r_mean [N_CH];
   logic [N_BITS-1:0]          r_ram [DEPTH];
   logic [N_BITS-1:0]          r_ram_q;
   logic [CH_BITS-1:0]         r_dv_ch;
   logic [BIT_BITS-1:0]        r_bit;
   logic                       r_neg;
   logic [ACC_BITS-1:0]        r_dividend;
   logic [RW-1:0]              r_rem;
   logic [ACC_BITS-2:0]        r_quot;
   logic                       r_rd_more;
   logic                       r_out_valid;
   logic [CH_BITS-1:0]         r_out_ch;
   logic [IDX_BITS-1:0]        r_out_idx;
   logic                       r_done;

   logic                       w_in_hs;
   logic                       w_out_hs;
   logic                       w_rd_en;
   logic                       w_cnt_end;
   logic                       w_out_end;
   logic                       w_ge;
   logic [REM_BITS-1:0]        w_trial;
   logic [ACC_BITS-1:0]        w_q_full;
   logic signed [ACC_BITS-1:0] w_acc_sel;
   logic signed [ACC_BITS-1:0] w_sample_ext;
   logic signed [N_BITS-1:0]   w_mean_sel;

   assign w_in_hs      = (r_state == S_LOAD) && io_bus.in_valid;
   assign w_out_hs     = r_out_valid && io_bus.out_ready;
   assign w_rd_en      = (r_state == S_EMIT) && r_rd_more && (!r_out_valid || io_bus.out_ready);
   assign w_cnt_end    = (r_ch == LAST_CH) && (r_idx == LAST_IDX);
   assign w_out_end    = (r_out_ch == LAST_CH) && (r_out_idx == LAST_IDX);
   assign w_sample_ext = {{(ACC_BITS-N_BITS){io_bus.in_data[N_BITS-1]}}, io_bus.in_data};
   assign w_acc_sel    = r_acc[r_dv_ch];
   assign w_trial      = {r_rem, r_dividend[ACC_BITS-1]};
   assign w_ge         = (w_trial >= DIVISOR);
   assign w_q_full     = {r_quot, w_ge};
   assign w_mean_sel   = r_mean[r_out_ch];

   assign io_bus.in_ready  = (r_state == S_LOAD);
   assign io_bus.out_valid = r_out_valid;
   assign io_bus.out_last  = r_out_valid && w_out_end;
   assign io_bus.out_ch    = r_out_ch;
   assign io_bus.out_idx   = r_out_idx;
   assign io_bus.out_data  = r_out_valid ?
                             ({r_ram_q[N_BITS-1], r_ram_q} - {w_mean_sel[N_BITS-1], w_mean_sel}) : '0;
   assign o_busy = (r_state != S_IDLE);
   assign o_done = r_done;

   // Frame buffer; the read register doubles as the output data stage so stalls hold it.
   always_ff @(posedge i_clk) begin
      if (w_in_hs) r_ram[r_addr] <= io_bus.in_data;
      if (w_rd_en) r_ram_q <= r_ram[r_addr];
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_ch        <= '0;
         r_idx       <= '0;
         r_addr      <= '0;
         r_dv_ch     <= '0;
         r_bit       <= '0;
         r_neg       <= 1'b0;
         r_dividend  <= '0;
         r_rem       <= '0;
         r_quot      <= '0;
         r_rd_more   <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_ch    <= '0;
         r_out_idx   <= '0;
         r_done      <= 1'b0;
         for (int i = 0; i < N_CH; i++) r_acc[i] <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_strt) begin
                  r_state <= S_LOAD;
                  r_ch    <= '0;
                  r_idx   <= '0;
                  r_addr  <= '0;
                  for (int i = 0; i < N_CH; i++) r_acc[i] <= '0;
               end
            end
            S_LOAD: begin
               if (w_in_hs) begin
                  r_acc[r_ch] <= r_acc[r_ch] + w_sample_ext;
                  r_addr      <= r_addr + ADDR_BITS'(1);
                  r_ch        <= (r_ch == LAST_CH) ? '0 : r_ch + CH_BITS'(1);
                  if (r_ch == LAST_CH) r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_BITS'(1);
                  if (w_cnt_end) begin
                     r_state <= S_DIVIDE;
                     r_dv_ch <= '0;
                     r_bit   <= '0;
                  end
               end
            end
            S_DIVIDE: begin
               // Step 0 latches |acc|; steps 1..ACC_BITS each resolve one quotient bit MSB first.
               if (r_bit == '0) begin
                  r_neg      <= w_acc_sel[ACC_BITS-1];
                  r_dividend <= w_acc_sel[ACC_BITS-1] ? -w_acc_sel : w_acc_sel;
                  r_rem      <= '0;
                  r_quot     <= '0;
               end else begin
                  r_rem      <= w_ge ? RW'(w_trial - DIVISOR) : w_trial[RW-1:0];
                  r_dividend <= r_dividend << 1;
                  r_quot     <= {r_quot[ACC_BITS-3:0], w_ge};
               end
               if (r_bit == LAST_BIT) begin
                  r_mean[r_dv_ch] <= r_neg ? N_BITS'(-w_q_full) : N_BITS'(w_q_full);
                  r_bit           <= '0;
                  if (r_dv_ch == LAST_CH) begin
                     r_state   <= S_EMIT;
                     r_ch      <= '0;
                     r_idx     <= '0;
                     r_addr    <= '0;
                     r_rd_more <= 1'b1;
                  end else begin
                     r_dv_ch <= r_dv_ch + CH_BITS'(1);
                  end
               end else begin
                  r_bit <= r_bit + BIT_BITS'(1);
               end
            end
            default: begin
               if (w_rd_en) begin
                  r_out_valid <= 1'b1;
                  r_out_ch    <= r_ch;
                  r_out_idx   <= r_idx;
                  r_addr      <= r_addr + ADDR_BITS'(1);
                  r_ch        <= (r_ch == LAST_CH) ? '0 : r_ch + CH_BITS'(1);
                  if (r_ch == LAST_CH) r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_BITS'(1);
                  if (w_cnt_end) r_rd_more <= 1'b0;
               end else if (w_out_hs) begin
                  r_out_valid <= 1'b0;
               end
               if (w_out_hs && w_out_end) begin
                  r_state     <= S_IDLE;
                  r_done      <= 1'b1;
                  r_out_valid <= 1'b0;
                  r_out_ch    <= '0;
                  r_out_idx   <= '0;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ecg_channel_center.sv
// tb/tb_ecg_channel_center.sv - Self-checking bench: table of frame scenarios against a behavioural mean model
module tb_ecg_channel_center;
   localparam int N_CH     = 8;
   localparam int N_SAMP   = 368;
   localparam int N_BITS   = 22;
   localparam int ACC_BITS = N_BITS + $clog2(N_SAMP);
   localparam int TOTAL    = N_CH * N_SAMP;
   localparam int DIV_CYC  = N_CH * (ACC_BITS + 1);
   localparam int MAXV     = (1 << (N_BITS - 1)) - 1;
   localparam int MINV     = -(1 << (N_BITS - 1));
   localparam int N_FR     = 6;
   localparam int BOUND    = 20000;

   typedef struct packed {
      int pat;
      int in_pct;
      int out_pct;
      bit lat;
      bit rst_before;
      bit poke;
      bit use_model;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic strt = 1'b0;
   logic busy;
   logic done;
   int   edge_ctr = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   int   fr [N_CH][N_SAMP];
   int   mean_c [N_CH];

   ecg_channel_center_if #(.N_CH(N_CH), .N_SAMP(N_SAMP), .N_BITS(N_BITS)) bus ();

   ecg_channel_center #(.N_CH(N_CH), .N_SAMP(N_SAMP), .N_BITS(N_BITS)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_strt  (strt),
      .o_busy  (busy),
      .o_done  (done),
      .io_bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_ctr <= edge_ctr + 1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic logic [39:0] outs();
      return {bus.in_ready, bus.out_valid, bus.out_last, busy, done,
              bus.out_data, bus.out_ch, bus.out_idx};
   endfunction

   function automatic int gen(input int pat, input int c, input int s);
      case (pat)
         0: return 5;
         1: return 100 * c + (s % 2);
         2: return (c == 0) ? ((s == 0) ? -367 : 0) : ((c == 1) ? -2 : 0);
         3: return (c == 0) ? MAXV : (c == 1) ? MINV : (c == 2) ? ((s % 2 == 0) ? MAXV : MINV) : 0;
         default: return (int'($urandom) >>> (11 + c % 4)) + (c - 4) * 50000;
      endcase
   endfunction

   task automatic partial_and_reset();
      int  e = 0;
      int  cyc = 0;
      bit  hs;
      strt = 1'b1;
      step();
      strt = 1'b0;
      while (e < 1000 && cyc < BOUND) begin
         bus.in_valid = 1'b1;
         bus.in_data  = N_BITS'(gen(4, e % N_CH, 0));
         hs = bus.in_ready;
         step();
         if (hs) e++;
         cyc++;
      end
      check("partial_load_count", e, 1000);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("midframe_reset_outputs", outs(), 0);
      step();
      check("reset_stays_idle", {bus.in_ready, busy}, 0);
      bus.in_valid = 1'b0;
   endtask

   task automatic run_frame(input int fi, input vec_t v);
      int          e = 0, n = 0, cyc = 0, mism = 0, hold_bad = 0, rdy_bad = 0;
      int          k_last = 0, first_edge = 0, exp_d;
      bit          hs, stalled = 0, seen_first = 0;
      logic [35:0] held = '0, cur;
      longint      sum;

      for (int c = 0; c < N_CH; c++) begin
         sum = 0;
         for (int s = 0; s < N_SAMP; s++) begin
            fr[c][s] = gen(v.pat, c, s);
            sum += fr[c][s];
         end
         if (v.use_model) mean_c[c] = int'(sum / N_SAMP);
      end

      strt = 1'b1;
      bus.out_ready = 1'b0;
      step();
      strt = 1'b0;
      check($sformatf("f%0d_start_busy_ready", fi), {busy, bus.in_ready, done}, 3'b110);

      while (e < TOTAL && cyc < BOUND) begin
         bus.in_valid = ($urandom_range(0, 99) < v.in_pct);
         bus.in_data  = N_BITS'(fr[e % N_CH][e / N_CH]);
         hs = bus.in_valid && bus.in_ready;
         step();
         if (hs) begin
            e++;
            k_last = edge_ctr;
         end
         cyc++;
      end
      bus.in_valid = 1'b0;
      check($sformatf("f%0d_load_count", fi), e, TOTAL);

      if (v.poke) begin
         strt = 1'b1;
         step();
         strt = 1'b0;
         check($sformatf("f%0d_strt_in_divide_ignored", fi), {busy, bus.in_ready, bus.out_valid}, 3'b100);
      end

      cyc = 0;
      while (n < TOTAL && cyc < BOUND) begin
         bus.out_ready = ($urandom_range(0, 99) < v.out_pct);
         if (bus.in_ready) rdy_bad++;
         cur = {bus.out_data, bus.out_ch, bus.out_idx, bus.out_last};
         if (bus.out_valid) begin
            if (!seen_first) begin
               seen_first = 1;
               first_edge = edge_ctr;
            end
            if (stalled && cur != held) hold_bad++;
            held    = cur;
            stalled = !bus.out_ready;
            if (bus.out_ready) begin
               exp_d = fr[n % N_CH][n / N_CH] - mean_c[n % N_CH];
               if (int'($signed(bus.out_data)) != exp_d || int'(bus.out_ch) != n % N_CH ||
                   int'(bus.out_idx) != n / N_CH || bus.out_last != (n == TOTAL - 1)) begin
                  mism++;
                  if (mism == 1)
                     $display("note: f%0d element %0d got d=%0d ch=%0d idx=%0d last=%0d, want d=%0d",
                              fi, n, $signed(bus.out_data), bus.out_ch, bus.out_idx, bus.out_last, exp_d);
               end
               n++;
            end
         end else if (stalled) begin
            hold_bad++;
            stalled = 0;
         end
         step();
         cyc++;
      end

      check($sformatf("f%0d_done_pulse", fi), {done, busy, bus.out_valid}, 3'b100);
      check($sformatf("f%0d_out_count", fi), n, TOTAL);
      check($sformatf("f%0d_out_data_errors", fi), mism, 0);
      check($sformatf("f%0d_hold_violations", fi), hold_bad, 0);
      check($sformatf("f%0d_in_ready_outside_load", fi), rdy_bad, 0);
      // First valid cycle k+DIV_CYC+2 is the cycle just after edge k+DIV_CYC+1.
      if (v.lat) check($sformatf("f%0d_first_out_latency", fi), first_edge - k_last, DIV_CYC + 1);
   endtask

   initial begin
      vec_t tbl [N_FR];
      int   tmean [N_FR][N_CH];

      tbl[0] = '{pat: 0, in_pct: 100, out_pct: 100, lat: 0, rst_before: 0, poke: 0, use_model: 0};
      tbl[1] = '{pat: 1, in_pct: 100, out_pct: 100, lat: 1, rst_before: 0, poke: 0, use_model: 0};
      tbl[2] = '{pat: 2, in_pct: 100, out_pct: 100, lat: 0, rst_before: 0, poke: 0, use_model: 0};
      tbl[3] = '{pat: 3, in_pct: 100, out_pct: 100, lat: 0, rst_before: 0, poke: 0, use_model: 0};
      tbl[4] = '{pat: 4, in_pct: 50,  out_pct: 30,  lat: 0, rst_before: 0, poke: 0, use_model: 1};
      tbl[5] = '{pat: 4, in_pct: 80,  out_pct: 70,  lat: 0, rst_before: 1, poke: 1, use_model: 1};
      for (int c = 0; c < N_CH; c++) begin
         tmean[0][c] = 5;
         tmean[1][c] = 100 * c;
         tmean[2][c] = (c == 1) ? -2 : 0;
         tmean[3][c] = (c == 0) ? MAXV : (c == 1) ? MINV : 0;
         tmean[4][c] = 0;
         tmean[5][c] = 0;
      end

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      rst_n = 1'b0;
      repeat (3) step();
      check("reset_outputs", outs(), 0);
      rst_n = 1'b1;
      step();
      check("idle_after_reset", {busy, bus.in_ready}, 0);

      for (int f = 0; f < N_FR; f++) begin
         if (tbl[f].rst_before) partial_and_reset();
         for (int c = 0; c < N_CH; c++) mean_c[c] = tmean[f][c];
         run_frame(f, tbl[f]);
      end

      step();
      check("done_single_cycle", {done, busy}, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/ecg_channel_center.md
# ecg_channel_center

Per-channel mean-removal stage for the fetal ECG separation pipeline. It sits directly upstream of the whitening and covariance stages. The block collects one full frame of multichannel ECG samples, computes each channel's arithmetic mean with an internal bit-serial divider, and streams the frame back out with the mean subtracted. The downstream matrix stages therefore receive zero-mean data in channel-interleaved order.

## Interface
- N_CH, 8: number of ECG channels.
- N_SAMP, 368: samples per channel per frame.
- N_BITS, 22: signed input sample width.
- ACC_BITS, N_BITS+$clog2(N_SAMP) (=31): signed accumulator and sum width.
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- strt  in  1  one-cycle start request; sampled only in IDLE.
- in_data  in  N_BITS  signed input sample.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  N_BITS+1  signed centered sample (sample − mean).
- out_ch  out  $clog2(N_CH)  channel index of out_data.
- out_idx  out  $clog2(N_SAMP)  sample index of out_data.
- out_last  out  1  high with the final frame element.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the final output handshake.

## Operation
- Frame order, both directions: sample-major, channel-minor, i.e. (s0,c0),(s0,c1)…(s0,cN_CH−1),(s1,c0)…
- Storage: internal N_CH·N_SAMP × N_BITS sample RAM with synchronous read; N_CH accumulators of ACC_BITS each; N_CH registered means of N_BITS each.
- States:
  - IDLE: no activity. On strt=1, go to LOAD and clear all accumulators and counters.
  - LOAD: in_ready=1. Each in_valid&in_ready handshake writes the sample to RAM and adds it, sign-extended, to acc[ch]. Counters advance per handshake; gaps in in_valid are allowed. The handshake that carries the last element → DIVIDE.
  - DIVIDE: channels are processed in order 0..N_CH−1. Per channel:
    - 1 setup cycle: latch |acc| and the sign.
    - ACC_BITS restoring-divide cycles by N_SAMP, one quotient bit per cycle.
    - The quotient's sign is then restored, giving truncation toward zero.
    - The result is stored as mean[ch]; it always fits in N_BITS.
    - After the last channel → EMIT.
  - EMIT: out_data = sext(ram) − sext(mean[out_ch]), computed at N_BITS+1 bits with no saturation. The next RAM read is prefetched so that back-to-back handshakes sustain one output per cycle. The handshake on out_last → IDLE, with done=1 on the following cycle.
- In every state except LOAD: in_ready=0 and in_valid is ignored.
- strt outside IDLE is ignored.
- Output hold: while out_valid=1 and out_ready=0, out_data, out_ch, out_idx and out_last stay stable.
- Reset, asserted at any time including mid-frame:
  - next state is IDLE;
  - accumulators and counters are cleared;
  - the partial frame is discarded;
  - all outputs go to 0: in_ready, out_valid, out_last, busy, done, out_data, out_ch, out_idx.

## Timing
- The input handshake completes in the same cycle in_valid and in_ready are both high. The output handshake works the same way with out_valid and out_ready.
- strt in IDLE at edge k: busy=1 and in_ready=1 from cycle k+1.
- DIVIDE duration: N_CH·(ACC_BITS+1) cycles; 256 with defaults.
- Last input handshake at edge k: first out_valid=1 at cycle k+N_CH·(ACC_BITS+1)+2, i.e. k+258 with defaults.
- EMIT throughput: 1 element/cycle when out_ready is held high, so the frame takes N_CH·N_SAMP = 2944 cycles minimum.
- done: high for exactly one cycle, the cycle after the out_last handshake. busy=0 in that same cycle.
- Minimum frame-to-frame gap: strt is accepted in the cycle done is high.

## Test plan
- Constant frame: every sample = 5 on all channels, out_ready=1. Expect mean=5, all 2944 outputs = 0, out_last only on (s367,c7), done 1 cycle later.
- Channel offsets: channel c sample s = 100·c + (s mod 2) − 0.5 pattern, i.e. s even → 100·c, s odd → 100·c+1. Sum = 36800·c+184, so mean = 100·c. Expect outputs alternating 0/1 per channel, first out_valid exactly 258 cycles after the last input handshake.
- Truncation and sign: channel 0 has one sample −367 and the rest 0, giving mean 0, so outputs equal the inputs. Channel 1 has all samples −2, giving mean −2, so outputs are 0.
- Extremes: channel 0 all +2^21−1, channel 1 all −2^21. Expect outputs 0, no overflow. Then channel 2 alternating +2^21−1/−2^21: sum −184, mean 0, outputs equal the inputs at 23-bit width.
- Backpressure and gaps: random in_valid (50%) and random out_ready (30%). Expect output identical to the golden model, out_* held stable during stalls, and no element lost or duplicated.
- Reset and strt misuse: rst_n=0 for one cycle after 1000 input handshakes. Expect the next cycle to show IDLE with all outputs 0. strt pulsed during DIVIDE is ignored. A fresh frame after reset produces correct means.
